stream_packet_arbiter: RTL and testbench
========================================

STREAM_PACKET_ARBITER -- requirements
Module: stream_packet_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: Avalon-ST data width of every data port.
REQ-002 clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-003 s0_valid/s0_sop/s0_eop  input  1 each  requester 0 sink sideband; s0_data  input  DATA_W  requester 0 data.
REQ-004 s0_ready  output  1  requester 0 backpressure.
REQ-005 s1_valid/s1_sop/s1_eop  input  1 each; s1_data  input  DATA_W; s1_ready  output  1  requester 1, same semantics.
REQ-006 m_valid/m_sop/m_eop  output  1 each; m_data  output  DATA_W  stream to shared DSP datapath.
REQ-007 m_channel  output  1  index of granted requester; m_ready  input  1  datapath backpressure.
REQ-008 enable  input  1  permits new grants; fixed_prio  input  1  1=requester 0 always wins, 0=round-robin.
REQ-009 clr  input  1  synchronous clear of counters and error flags.
REQ-010 pkt_cnt0, pkt_cnt1  output  16 each  completed packets per requester; busy  output  1  grant active.
REQ-011 err_orphan, err_sop  output  1 each  sticky protocol error flags.

Function
REQ-012 States IDLE, GRANT0, GRANT1; beat accepted = valid & ready on the same port.
REQ-013 IDLE: m_valid=0, m_sop=0, m_eop=0, busy=0; a requester is eligible when sX_valid=1 and sX_sop=1.
REQ-014 IDLE with enable=1 and >=1 eligible: transition to GRANTx next cycle; the beat is not forwarded in the decision cycle (1-cycle arbitration latency).
REQ-015 Both eligible, fixed_prio=1: GRANT0; fixed_prio=0: grant the requester not in last_grant.
REQ-016 last_grant updates on every IDLE->GRANTx transition.
REQ-017 GRANTx: m_valid/m_sop/m_eop/m_data combinationally follow sX_*; sX_ready=m_ready; other requester's ready=0; m_channel=x; busy=1.
REQ-018 GRANTx: beat accepted with sX_eop=1 -> IDLE next cycle, giving exactly one idle cycle between packets.
REQ-019 Single-beat packet (sop=eop=1) completes in one GRANT cycle.
REQ-020 enable deassertion during GRANTx does not truncate; the packet completes and no new grant is issued.
REQ-021 IDLE: a requester with sX_valid=1 and sX_sop=0 gets sX_ready=1, its beat is discarded, and err_orphan sets.
REQ-022 GRANTx: accepted beat with sX_sop=1 other than the first beat of the grant sets err_sop; the beat is still forwarded.
REQ-023 pkt_cntX increments by 1 on an accepted eop beat in GRANTx and wraps 0xFFFF->0x0000.
REQ-024 clr=1 forces counters and flags to 0 next cycle, overriding a same-cycle increment or error event.
REQ-025 m_channel=0 and m_data=0 in IDLE.

Reset
REQ-026 rst_n low: state=IDLE, last_grant=1 (requester 0 wins first round-robin), counters=0, flags=0.
REQ-027 During reset: all ready and m_* outputs are 0, busy=0.
REQ-028 Reset mid-packet abandons the packet with no eop emitted; the next grant requires a new sop.

Structure
REQ-029 Shared package dsp_stream_pkg holds the state enum, the DATA_W default and the 16-bit counter width constant.
REQ-030 One sub-module, rr_arb2, implements the 2-way round-robin/fixed-priority choice and the last_grant register.

Verification
REQ-031 Reset, then s0 sends a 3-beat packet (0x11,0x22,0x33) with m_ready=1 -> m_data sequence after 1 idle cycle, m_channel=0, pkt_cnt0=1.
REQ-032 Both eligible every packet, fixed_prio=0, four 2-beat packets each -> grants alternate 0,1,0,1,... with one idle cycle between packets.
REQ-033 Same as REQ-032 with fixed_prio=1 -> all s0 packets complete before any s1 grant.
REQ-034 m_ready toggled 1,0,0,1 during s1 packet -> s1_ready mirrors m_ready and there is no beat loss or duplication.
REQ-035 s1 drives valid=1, sop=0 while IDLE -> beat consumed, err_orphan=1; clr pulse -> err_orphan=0.
REQ-036 pkt_cnt0 preloaded by 65535 packets, then one more -> 0x0000; enable=0 mid-packet -> packet finishes, busy=0, no regrant.

Source files
------------

// File: rtl/dsp_stream_pkg.sv
// ------------------------------------------------------------------
// dsp_stream_pkg : shared types/constants for the DSP stream arbiter
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dsp_stream_pkg;

   localparam int DATA_W_DEFAULT = 32;
   localparam int CNT_W          = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ------------------------------------------------------------------
// rr_arb2 : 2-way round-robin / fixed-priority chooser with history
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic fixed_prio,
   input  logic take,
   output logic gnt_any,
   output logic gnt_idx
);

   logic r_last_grant;

   // Contention favours requester 0 under fixed priority, otherwise the one not served last.
   always_comb begin
      gnt_any = req0 | req1;
      if (req0 && req1) begin
         gnt_idx = fixed_prio ? 1'b0 : ~r_last_grant;
      end else begin
         gnt_idx = req1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (take && gnt_any) begin
         r_last_grant <= gnt_idx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/stream_packet_arbiter.sv
// ------------------------------------------------------------------
// stream_packet_arbiter : 2-to-1 Avalon-ST packet arbiter with stats
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module stream_packet_arbiter
   import dsp_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s0_valid,
   input  logic              s0_sop,
   input  logic              s0_eop,
   input  logic [DATA_W-1:0] s0_data,
   output logic              s0_ready,
   input  logic              s1_valid,
   input  logic              s1_sop,
   input  logic              s1_eop,
   input  logic [DATA_W-1:0] s1_data,
   output logic              s1_ready,
   output logic              m_valid,
   output logic              m_sop,
   output logic              m_eop,
   output logic [DATA_W-1:0] m_data,
   output logic              m_channel,
   input  logic              m_ready,
   input  logic              enable,
   input  logic              fixed_prio,
   input  logic              clr,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1,
   output logic              busy,
   output logic              err_orphan,
   output logic              err_sop
);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic             r_first;
   logic [CNT_W-1:0] r_pkt_cnt0;
   logic [CNT_W-1:0] r_pkt_cnt1;
   logic             r_err_orphan;
   logic             r_err_sop;

   logic w_elig0;
   logic w_elig1;
   logic w_take;
   logic w_gnt_any;
   logic w_gnt_idx;
   logic w_acc;
   logic w_acc_sop;
   logic w_done0;
   logic w_done1;
   logic w_orphan;

   assign w_elig0 = s0_valid & s0_sop;
   assign w_elig1 = s1_valid & s1_sop;
   assign w_take  = (r_state == ST_IDLE) & enable;

   rr_arb2 u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (w_elig0),
      .req1       (w_elig1),
      .fixed_prio (fixed_prio),
      .take       (w_take),
      .gnt_any    (w_gnt_any),
      .gnt_idx    (w_gnt_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      m_valid     = 1'b0;
      m_sop       = 1'b0;
      m_eop       = 1'b0;
      m_data      = '0;
      m_channel   = 1'b0;
      s0_ready    = 1'b0;
      s1_ready    = 1'b0;
      busy        = 1'b0;
      w_acc       = 1'b0;
      w_acc_sop   = 1'b0;
      w_done0     = 1'b0;
      w_done1     = 1'b0;
      w_orphan    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Beats arriving without a packet context are drained and flagged.
            s0_ready = rst_n & s0_valid & ~s0_sop;
            s1_ready = rst_n & s1_valid & ~s1_sop;
            w_orphan = s0_ready | s1_ready;
            if (w_take && w_gnt_any) begin
               w_state_nxt = w_gnt_idx ? ST_GRANT1 : ST_GRANT0;
            end
         end
         ST_GRANT0: begin
            m_valid   = s0_valid;
            m_sop     = s0_sop;
            m_eop     = s0_eop;
            m_data    = s0_data;
            s0_ready  = m_ready;
            busy      = 1'b1;
            w_acc     = s0_valid & m_ready;
            w_acc_sop = s0_sop;
            w_done0   = w_acc & s0_eop;
            if (w_done0) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GRANT1: begin
            m_valid   = s1_valid;
            m_sop     = s1_sop;
            m_eop     = s1_eop;
            m_data    = s1_data;
            m_channel = 1'b1;
            s1_ready  = m_ready;
            busy      = 1'b1;
            w_acc     = s1_valid & m_ready;
            w_acc_sop = s1_sop;
            w_done1   = w_acc & s1_eop;
            if (w_done1) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // r_first marks the opening beat of a grant; any later sop is a protocol error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_first <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_first <= 1'b1;
      end else if (w_acc) begin
         r_first <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt0   <= '0;
         r_pkt_cnt1   <= '0;
         r_err_orphan <= 1'b0;
         r_err_sop    <= 1'b0;
      end else if (clr) begin
         r_pkt_cnt0   <= '0;
         r_pkt_cnt1   <= '0;
         r_err_orphan <= 1'b0;
         r_err_sop    <= 1'b0;
      end else begin
         if (w_done0) begin
            r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
         end
         if (w_done1) begin
            r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
         end
         if (w_orphan) begin
            r_err_orphan <= 1'b1;
         end
         if (w_acc && w_acc_sop && !r_first) begin
            r_err_sop <= 1'b1;
         end
      end
   end

   assign pkt_cnt0   = r_pkt_cnt0;
   assign pkt_cnt1   = r_pkt_cnt1;
   assign err_orphan = r_err_orphan;
   assign err_sop    = r_err_sop;

endmodule

`default_nettype wire

// File: tb/tb_stream_packet_arbiter.sv
// ------------------------------------------------------------------
// tb_stream_packet_arbiter : self-checking bench for the packet arbiter
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_stream_packet_arbiter;

   localparam int DW = 32;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s0_valid, s0_sop, s0_eop, s0_ready;
   logic [DW-1:0] s0_data;
   logic          s1_valid, s1_sop, s1_eop, s1_ready;
   logic [DW-1:0] s1_data;
   logic          m_valid, m_sop, m_eop, m_channel, m_ready;
   logic [DW-1:0] m_data;
   logic          enable, fixed_prio, clr;
   logic [15:0]   pkt_cnt0, pkt_cnt1;
   logic          busy, err_orphan, err_sop;

   always #5 clk = ~clk;

   stream_packet_arbiter #(.DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_valid(s0_valid), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_data(s0_data), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_data(s1_data), .s1_ready(s1_ready),
      .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_data(m_data),
      .m_channel(m_channel), .m_ready(m_ready),
      .enable(enable), .fixed_prio(fixed_prio), .clr(clr),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy),
      .err_orphan(err_orphan), .err_sop(err_sop)
   );

   typedef struct {logic sop; logic eop; logic [DW-1:0] data;} beat_t;
   typedef struct {logic ch; logic sop; logic eop; logic [DW-1:0] data;} exp_t;
   typedef struct {
      logic en, fp, v0, p0, v1, p1;
      logic r0, r1, bn, ch, orph;
   } vec_t;

   beat_t q0[$];
   beat_t q1[$];
   exp_t  sb[$];
   logic  mr_q[$];
   vec_t  vt[12];
   int    n_cmp = 0;
   int    n_err = 0;
   logic  prev_eop = 1'b0;
   logic [15:0] e_cnt0, e_cnt1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      if (q0.size() > 0) begin
         s0_valid = 1'b1; s0_sop = q0[0].sop; s0_eop = q0[0].eop; s0_data = q0[0].data;
      end else begin
         s0_valid = 1'b0; s0_sop = 1'b0; s0_eop = 1'b0; s0_data = '0;
      end
      if (q1.size() > 0) begin
         s1_valid = 1'b1; s1_sop = q1[0].sop; s1_eop = q1[0].eop; s1_data = q1[0].data;
      end else begin
         s1_valid = 1'b0; s1_sop = 1'b0; s1_eop = 1'b0; s1_data = '0;
      end
      m_ready = (mr_q.size() > 0) ? mr_q.pop_front() : 1'b1;
   endtask

   task automatic monitor();
      exp_t e;
      if (busy && sb.size() > 0)
         chk("ready_mirror", {s0_ready, s1_ready}, sb[0].ch ? {1'b0, m_ready} : {m_ready, 1'b0});
      if (!busy)
         chk("idle_outputs", {m_valid, m_sop, m_eop, m_channel, m_data}, 64'd0);
      if (prev_eop)
         chk("gap_idle", busy, 64'd0);
      if (m_valid && m_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_extra: got beat 0x%0h, want none", m_data);
         end else begin
            e = sb.pop_front();
            chk("beat", {m_channel, m_sop, m_eop, m_data}, {e.ch, e.sop, e.eop, e.data});
         end
      end
      prev_eop = m_valid && m_ready && m_eop;
   endtask

   task automatic step();
      logic a0, a1;
      @(negedge clk);
      a0 = s0_valid && s0_ready;
      a1 = s1_valid && s1_ready;
      monitor();
      tick();
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      drive();
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < bound) begin
         step();
         n++;
      end
      chk("drain_pending", q0.size() + q1.size() + sb.size(), 64'd0);
      step();
   endtask

   task automatic push_src(input logic port, input int nb, input logic [DW-1:0] base);
      beat_t b;
      for (int i = 0; i < nb; i++) begin
         b.sop  = (i == 0);
         b.eop  = (i == nb - 1);
         b.data = base * DW'(i + 1);
         if (port) q1.push_back(b);
         else      q0.push_back(b);
      end
   endtask

   task automatic push_exp(input logic port, input int nb, input logic [DW-1:0] base);
      exp_t e;
      for (int i = 0; i < nb; i++) begin
         e.ch   = port;
         e.sop  = (i == 0);
         e.eop  = (i == nb - 1);
         e.data = base * DW'(i + 1);
         sb.push_back(e);
      end
      if (port) e_cnt1++;
      else      e_cnt0++;
   endtask

   task automatic reset_dut();
      s0_valid = 1'b1; s0_sop = 1'b0; s0_eop = 1'b0; s0_data = '0;
      s1_valid = 1'b0; s1_sop = 1'b0; s1_eop = 1'b0; s1_data = '0;
      clr = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_ready", {s0_ready, s1_ready}, 64'd0);
      chk("rst_m_out", {busy, m_valid, m_sop, m_eop, m_channel, m_data}, 64'd0);
      chk("rst_cnt", {pkt_cnt0, pkt_cnt1}, 64'd0);
      chk("rst_flags", {err_orphan, err_sop}, 64'd0);
      tick();
      tick();
      s0_valid = 1'b0;
      rst_n = 1'b1;
      q0.delete(); q1.delete(); sb.delete(); mr_q.delete();
      prev_eop = 1'b0;
      e_cnt0 = '0;
      e_cnt1 = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      s0_valid = 0; s0_sop = 0; s0_eop = 0; s0_data = '0;
      s1_valid = 0; s1_sop = 0; s1_eop = 0; s1_data = '0;
      m_ready = 1; enable = 0; fixed_prio = 0; clr = 0; rst_n = 0;
      e_cnt0 = '0; e_cnt1 = '0;

      //          en fp v0 p0 v1 p1   r0 r1 bn ch orph
      vt[0]  = '{T, F, F, F, F, F,   F, F, F, F, F};
      vt[1]  = '{T, F, T, F, F, F,   T, F, F, F, T};
      vt[2]  = '{F, F, T, T, T, T,   F, F, F, F, F};
      vt[3]  = '{T, F, T, T, T, T,   F, F, T, F, F};
      vt[4]  = '{T, F, T, T, T, T,   F, F, T, T, F};
      vt[5]  = '{T, T, T, T, T, T,   F, F, T, F, F};
      vt[6]  = '{T, T, T, T, T, T,   F, F, T, F, F};
      vt[7]  = '{T, F, F, F, T, T,   F, F, T, T, F};
      vt[8]  = '{T, F, T, T, T, F,   F, T, T, F, T};
      vt[9]  = '{T, F, T, F, T, T,   T, F, T, T, T};
      vt[10] = '{T, F, T, T, T, T,   F, F, T, F, F};
      vt[11] = '{F, F, F, F, T, F,   F, T, F, F, T};

      reset_dut();

      // Arbitration decision table, each grant closed by a lone eop beat.
      for (int i = 0; i < 12; i++) begin
         enable = vt[i].en; fixed_prio = vt[i].fp; m_ready = 1'b1;
         s0_valid = vt[i].v0; s0_sop = vt[i].p0; s0_eop = 1'b0;
         s1_valid = vt[i].v1; s1_sop = vt[i].p1; s1_eop = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), {s0_ready, s1_ready}, {vt[i].r0, vt[i].r1});
         chk($sformatf("vec%0d_idle", i), {busy, m_valid}, 64'd0);
         tick();
         chk($sformatf("vec%0d_busy", i), busy, vt[i].bn);
         if (vt[i].bn) chk($sformatf("vec%0d_chan", i), m_channel, vt[i].ch);
         chk($sformatf("vec%0d_orphan", i), err_orphan, vt[i].orph);
         s0_valid = 0; s0_sop = 0; s1_valid = 0; s1_sop = 0;
         if (vt[i].bn) begin
            if (vt[i].ch) begin s1_valid = 1; s1_eop = 1; end
            else          begin s0_valid = 1; s0_eop = 1; end
            tick();
            s0_valid = 0; s0_eop = 0; s1_valid = 0; s1_eop = 0;
         end
         clr = 1'b1;
         tick();
         clr = 1'b0;
      end

      // Single 3-beat packet on requester 0.
      reset_dut();
      enable = 1; fixed_prio = 0;
      push_src(0, 3, 32'h11);
      push_exp(0, 3, 32'h11);
      drive();
      drain(50);
      chk("a_cnt0", pkt_cnt0, 16'd1);

      // Round-robin alternation from a fresh reset.
      reset_dut();
      enable = 1; fixed_prio = 0;
      for (int k = 0; k < 4; k++) begin
         push_src(0, 2, 32'h100 + k * 16);
         push_src(1, 2, 32'h200 + k * 16);
      end
      for (int k = 0; k < 4; k++) begin
         push_exp(0, 2, 32'h100 + k * 16);
         push_exp(1, 2, 32'h200 + k * 16);
      end
      drive();
      drain(100);
      chk("b_cnt", {pkt_cnt0, pkt_cnt1}, {e_cnt0, e_cnt1});

      // Fixed priority: requester 0 drains completely first.
      fixed_prio = 1;
      for (int k = 0; k < 4; k++) begin
         push_src(0, 2, 32'h400 + k * 16);
         push_src(1, 2, 32'h500 + k * 16);
      end
      for (int k = 0; k < 4; k++) push_exp(0, 2, 32'h400 + k * 16);
      for (int k = 0; k < 4; k++) push_exp(1, 2, 32'h500 + k * 16);
      drive();
      drain(100);
      chk("c_cnt", {pkt_cnt0, pkt_cnt1}, {e_cnt0, e_cnt1});

      // Downstream backpressure during a requester 1 packet.
      fixed_prio = 0;
      push_src(1, 3, 32'h300);
      push_exp(1, 3, 32'h300);
      mr_q.push_back(1); mr_q.push_back(1); mr_q.push_back(0);
      mr_q.push_back(0); mr_q.push_back(1);
      drive();
      drain(50);
      chk("d_cnt1", pkt_cnt1, e_cnt1);

      // Orphan beat on requester 1, then clear.
      q1.push_back('{1'b0, 1'b0, 32'hDEAD});
      drive();
      drain(10);
      chk("e_orphan_set", err_orphan, 64'd1);
      clr = 1; tick(); clr = 0;
      chk("e_orphan_clr", err_orphan, 64'd0);

      // Repeated sop inside a packet is flagged but still forwarded.
      q0.push_back('{1'b1, 1'b0, 32'h51});
      q0.push_back('{1'b1, 1'b0, 32'h52});
      q0.push_back('{1'b0, 1'b1, 32'h53});
      sb.push_back('{1'b0, 1'b1, 1'b0, 32'h51});
      sb.push_back('{1'b0, 1'b1, 1'b0, 32'h52});
      sb.push_back('{1'b0, 1'b0, 1'b1, 32'h53});
      chk("f_sop_pre", err_sop, 64'd0);
      drive();
      drain(20);
      chk("f_sop_set", err_sop, 64'd1);
      clr = 1; tick(); clr = 0;
      chk("f_clr", {err_sop, pkt_cnt0, pkt_cnt1}, 64'd0);

      // clr on the cycle of an eop acceptance wins over the increment.
      push_src(0, 1, 32'h61);
      push_exp(0, 1, 32'h61);
      drive();
      step();
      clr = 1;
      step();
      clr = 0;
      drain(10);
      chk("g_clr_override", pkt_cnt0, 64'd0);

      // Counter wrap from 0xFFFF.
      force dut.r_pkt_cnt0 = 16'hFFFF;
      tick();
      release dut.r_pkt_cnt0;
      tick();
      chk("h_preload", pkt_cnt0, 16'hFFFF);
      push_src(0, 1, 32'h71);
      push_exp(0, 1, 32'h71);
      drive();
      drain(10);
      chk("h_wrap", pkt_cnt0, 16'h0000);

      // enable dropped mid-packet: packet completes, nothing new is granted.
      fixed_prio = 1;
      push_src(0, 3, 32'h700);
      push_exp(0, 3, 32'h700);
      push_src(1, 1, 32'h800);
      drive();
      step();
      step();
      enable = 0;
      for (int n = 0; n < 20 && sb.size() > 0; n++) step();
      chk("i_pkt_done", sb.size(), 64'd0);
      for (int n = 0; n < 4; n++) begin
         step();
         chk("i_no_regrant", busy, 64'd0);
      end
      chk("i_cnt0", pkt_cnt0, 16'd1);
      enable = 1;
      push_exp(1, 1, 32'h800);
      drain(20);
      chk("i_cnt1_after", pkt_cnt1, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
